// File: rtl/rr_bus_arb4_8.sv
// Round-robin arbiter for four requesters sharing one 4:1 data mux.
// Issues registered one-hot grants, bounds hold time, and registers the selected data with its source tag.
module rr_bus_arb4_8 #(
    parameter int unsigned MAX_HOLD = 8,
    parameter int unsigned DATA_W   = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [3:0]        req,
    input  logic [DATA_W-1:0] Din0,
    input  logic [DATA_W-1:0] Din1,
    input  logic [DATA_W-1:0] Din2,
    input  logic [DATA_W-1:0] Din3,
    output logic [3:0]        grant,
    output logic [1:0]        select,
    output logic              busy,
    output logic [DATA_W-1:0] Dout,
    output logic              Dout_valid,
    output logic [1:0]        Dout_src
);

    localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    // First requester after 'last' in circular order; 'last' itself is checked last.
    function automatic logic [1:0] rr_pick(input logic [3:0] cand, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        logic       found;
        pick  = last;
        found = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            idx = last + 2'(k);
            if (!found && cand[idx]) begin
                pick  = idx;
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return pick;
    endfunction

    function automatic logic [3:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [3:0]        grant_r;
    logic [3:0]        grant_nxt_s;
    logic [1:0]        select_r;
    logic [1:0]        select_nxt_s;
    logic              busy_r;
    logic [7:0]        hold_cnt_r;
    logic [7:0]        hold_nxt_s;
    logic [1:0]        last_owner_r;
    logic [1:0]        last_nxt_s;
    logic [3:0]        cand_s;
    logic              cand_any_s;
    logic [1:0]        pick_s;
    logic [DATA_W-1:0] din_sel_s;
    logic [DATA_W-1:0] dout_r;
    logic              dout_valid_r;
    logic [1:0]        dout_src_r;

    // Candidate set: while owned, only requesters other than the owner compete.
    always_comb begin
        cand_s = 4'b0000;
        if (state_r == ST_OWNED) begin
            cand_s = req & ~grant_r;
        end else begin
            cand_s = req;
        end
    end

    assign cand_any_s = |cand_s;
    assign pick_s     = rr_pick(cand_s, last_owner_r);

    // Next-state, grant and hold-counter logic.
    always_comb begin
        state_nxt_s  = state_r;
        grant_nxt_s  = grant_r;
        select_nxt_s = select_r;
        hold_nxt_s   = hold_cnt_r;
        last_nxt_s   = last_owner_r;
        case (state_r)
            ST_IDLE: begin
                if (cand_any_s) begin
                    state_nxt_s  = ST_OWNED;
                    grant_nxt_s  = onehot4(pick_s);
                    select_nxt_s = pick_s;
                    last_nxt_s   = pick_s;
                    hold_nxt_s   = 8'd0;
                end else begin
                    state_nxt_s = ST_IDLE;
                    grant_nxt_s = 4'b0000;
                    hold_nxt_s  = 8'd0;
                end
            end
            ST_OWNED: begin
                // Release takes precedence; a simultaneous preempt gives the same regrant anyway.
                if (!req[select_r]) begin
                    if (cand_any_s) begin
                        grant_nxt_s  = onehot4(pick_s);
                        select_nxt_s = pick_s;
                        last_nxt_s   = pick_s;
                        hold_nxt_s   = 8'd0;
                    end else begin
                        state_nxt_s = ST_IDLE;
                        grant_nxt_s = 4'b0000;
                        hold_nxt_s  = 8'd0;
                    end
                end else if ((hold_cnt_r == HOLD_LAST) && cand_any_s) begin
                    grant_nxt_s  = onehot4(pick_s);
                    select_nxt_s = pick_s;
                    last_nxt_s   = pick_s;
                    hold_nxt_s   = 8'd0;
                end else if (hold_cnt_r == HOLD_LAST) begin
                    hold_nxt_s = HOLD_LAST;
                end else begin
                    hold_nxt_s = hold_cnt_r + 8'd1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                grant_nxt_s = 4'b0000;
                hold_nxt_s  = 8'd0;
            end
        endcase
    end

    // Arbitration state registers.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r      <= ST_IDLE;
            grant_r      <= 4'b0000;
            select_r     <= 2'd0;
            busy_r       <= 1'b0;
            hold_cnt_r   <= 8'd0;
            last_owner_r <= 2'd3;
        end else begin
            state_r      <= state_nxt_s;
            grant_r      <= grant_nxt_s;
            select_r     <= select_nxt_s;
            busy_r       <= |grant_nxt_s;
            hold_cnt_r   <= hold_nxt_s;
            last_owner_r <= last_nxt_s;
        end
    end

    // Shared 4:1 data mux driven by the registered select.
    always_comb begin
        din_sel_s = Din0;
        case (select_r)
            2'd0:    din_sel_s = Din0;
            2'd1:    din_sel_s = Din1;
            2'd2:    din_sel_s = Din2;
            2'd3:    din_sel_s = Din3;
            default: din_sel_s = Din0;
        endcase
    end

    // Output data register; data and tag hold while idle, only valid drops.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
            dout_src_r   <= 2'd0;
        end else if (grant_r != 4'b0000) begin
            dout_r       <= din_sel_s;
            dout_valid_r <= 1'b1;
            dout_src_r   <= select_r;
        end else begin
            dout_valid_r <= 1'b0;
        end
    end

    assign grant      = grant_r;
    assign select     = select_r;
    assign busy       = busy_r;
    assign Dout       = dout_r;
    assign Dout_valid = dout_valid_r;
    assign Dout_src   = dout_src_r;

endmodule

// File: tb/tb_rr_bus_arb4_8.sv
// Scoreboard bench for rr_bus_arb4_8: directed steps queue expected outputs, a monitor pops and compares.
module tb_rr_bus_arb4_8;

    logic       Clk = 1'b0;
    logic       Reset_n;
    logic [3:0] req;
    logic [7:0] Din0, Din1, Din2, Din3;
    logic [3:0] grant;
    logic [1:0] select;
    logic       busy;
    logic [7:0] Dout;
    logic       Dout_valid;
    logic [1:0] Dout_src;

    rr_bus_arb4_8 #(.MAX_HOLD(8), .DATA_W(8)) dut (
        .Clk(Clk), .Reset_n(Reset_n), .req(req),
        .Din0(Din0), .Din1(Din1), .Din2(Din2), .Din3(Din3),
        .grant(grant), .select(select), .busy(busy),
        .Dout(Dout), .Dout_valid(Dout_valid), .Dout_src(Dout_src)
    );

    always #5 Clk = ~Clk;

    typedef struct {
        logic [3:0] grant;
        logic       busy;
        logic [1:0] sel;
        logic       dv;
        logic [7:0] dout;
        logic [1:0] src;
    } exp_t;

    exp_t  exp_q[$];
    string name_q[$];
    int    vectors = 0;
    int    miscompares = 0;
    event  mon_ev;
    logic [7:0] din_tab [4];

    task automatic push(input string nm, input logic [3:0] g, input logic [1:0] s,
                        input logic dv, input logic [7:0] d, input logic [1:0] src);
        exp_t e;
        e.grant = g;
        e.busy  = |g;
        e.sel   = s;
        e.dv    = dv;
        e.dout  = d;
        e.src   = src;
        exp_q.push_back(e);
        name_q.push_back(nm);
    endtask

    // Drive inputs for the next rising edge and queue what the outputs must be after it.
    task automatic step(input string nm, input logic rst, input logic [3:0] r, input logic [7:0] d3,
                        input logic [3:0] g, input logic [1:0] s, input logic dv,
                        input logic [7:0] d, input logic [1:0] src);
        @(negedge Clk);
        Reset_n = rst;
        req     = r;
        Din3    = d3;
        push(nm, g, s, dv, d, src);
    endtask

    always @(posedge Clk) begin
        #1;
        -> mon_ev;
    end

    initial begin : monitor
        exp_t  e;
        string nm;
        forever begin
            @(mon_ev);
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                vectors++;
                if (grant !== e.grant || busy !== e.busy || select !== e.sel ||
                    Dout_valid !== e.dv || Dout !== e.dout || Dout_src !== e.src) begin
                    miscompares++;
                    $display("FAIL %s @%0t: got grant=%b busy=%b sel=%0d dv=%b dout=%h src=%0d, expected grant=%b busy=%b sel=%0d dv=%b dout=%h src=%0d",
                             nm, $time, grant, busy, select, Dout_valid, Dout, Dout_src,
                             e.grant, e.busy, e.sel, e.dv, e.dout, e.src);
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        int own;
        int prev;
        din_tab[0] = 8'h10;
        din_tab[1] = 8'h21;
        din_tab[2] = 8'h32;
        din_tab[3] = 8'h43;
        Reset_n = 1'b0;
        req     = 4'b1111;
        Din0    = 8'h10;
        Din1    = 8'h21;
        Din2    = 8'h32;
        Din3    = 8'h43;

        // Reset held with all requests high, then the first grant goes to requester 0.
        step("reset",       1'b0, 4'b1111, 8'h43, 4'b0000, 2'd0, 1'b0, 8'h00, 2'd0);
        step("first_grant", 1'b1, 4'b1111, 8'h43, 4'b0001, 2'd0, 1'b0, 8'h00, 2'd0);

        // All requesting: owners 0,1,2,3,0 for 8 cycles each, data trails by one cycle.
        for (int n = 2; n <= 33; n++) begin
            own  = ((n - 1) / 8) % 4;
            prev = ((n - 2) / 8) % 4;
            step("round_robin", 1'b1, 4'b1111, 8'h43, 4'(4'b0001 << own), 2'(own),
                 1'b1, din_tab[prev], 2'(prev));
        end

        // Owner 0 releases to 1, then 1 releases straight to 2 with no idle cycle.
        step("release_to_1",      1'b1, 4'b0110, 8'h43, 4'b0010, 2'd1, 1'b1, 8'h10, 2'd0);
        step("release_no_bubble", 1'b1, 4'b0100, 8'h43, 4'b0100, 2'd2, 1'b1, 8'h21, 2'd1);

        // Lone owner keeps the bus past MAX_HOLD, then is preempted as soon as 0 requests.
        for (int i = 0; i < 40; i++) begin
            step("lone_owner", 1'b1, 4'b0100, 8'h43, 4'b0100, 2'd2, 1'b1, 8'h32, 2'd2);
        end
        step("preempt", 1'b1, 4'b0101, 8'h43, 4'b0001, 2'd0, 1'b1, 8'h32, 2'd2);

        // Datapath through owner 3, then release to idle and valid drop.
        step("to_owner3",    1'b1, 4'b1000, 8'h43, 4'b1000, 2'd3, 1'b1, 8'h10, 2'd0);
        step("dout_a5",      1'b1, 4'b1000, 8'hA5, 4'b1000, 2'd3, 1'b1, 8'hA5, 2'd3);
        step("dout_3c",      1'b1, 4'b1000, 8'h3C, 4'b1000, 2'd3, 1'b1, 8'h3C, 2'd3);
        step("release_idle", 1'b1, 4'b0000, 8'h3C, 4'b0000, 2'd3, 1'b1, 8'h3C, 2'd3);
        step("valid_drop",   1'b1, 4'b0000, 8'h3C, 4'b0000, 2'd3, 1'b0, 8'h3C, 2'd3);

        // From idle after owner 3, requester 1 wins; then reset asynchronously mid-grant.
        step("grant1",      1'b1, 4'b0010, 8'h3C, 4'b0010, 2'd1, 1'b0, 8'h3C, 2'd3);
        step("grant1_data", 1'b1, 4'b0010, 8'h3C, 4'b0010, 2'd1, 1'b1, 8'h21, 2'd1);
        @(posedge Clk);
        #3;
        Reset_n = 1'b0;
        #1;
        push("async_reset", 4'b0000, 2'd0, 1'b0, 8'h00, 2'd0);
        -> mon_ev;
        step("reset_held",    1'b0, 4'b0000, 8'h3C, 4'b0000, 2'd0, 1'b0, 8'h00, 2'd0);
        step("reset_release", 1'b1, 4'b0000, 8'h3C, 4'b0000, 2'd0, 1'b0, 8'h00, 2'd0);

        for (int i = 0; i < 5 && exp_q.size() > 0; i++) begin
            @(posedge Clk);
            #2;
        end
        if (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL drain: got %0d pending expectations, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
